data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressable, big-endian data memory with a request/response handshake and configurable access latency.
- Supports byte, halfword and word loads and stores; loads can be sign- or zero-extended.
- Detects misaligned, out-of-range and invalid-size accesses.
- Sits on the MIPS datapath MEM stage in place of the single-cycle word memory; the pipeline stalls while busy is high.

Parameters:
- ADDR_WIDTH, 14, byte-address bits actually decoded; memory holds 2**ADDR_WIDTH bytes (16 KB default).
- LATENCY, 1, wait cycles inserted between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = invalid.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  output  1  one-cycle pulse marking a completed access.
- resp_rdata  output  32  load result; 0 unless resp_valid is high and the access is a successful load.
- resp_error  output  1  qualifies resp_valid; access rejected.
- busy  output  1  request in flight (not IDLE).

Behaviour:
- Reset (asynchronous assert, synchronous release): FSM returns to IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch write, size, unsigned, addr and wdata, and compute the error flag. Go to WAIT if LATENCY>0, else to RESP.
  - WAIT: 4-bit counter loaded with LATENCY-1 on acceptance; decrements each cycle; go to RESP on the cycle the counter is 0.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Timing:
  - Request accepted at edge N → resp_valid high during cycle N+LATENCY+1.
  - Throughput: one access per LATENCY+2 cycles.
  - req_ready=0 and busy=1 in WAIT and RESP; req_valid is ignored there.
- Error conditions, evaluated on the latched request:
  - req_size=11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠00.
  - addr[31:ADDR_WIDTH]≠0.
  - Any error: resp_error=1, resp_rdata=0, no memory write.
- Endianness: byte at address a is most significant.
  - Word load = {m[a], m[a+1], m[a+2], m[a+3]}.
  - Halfword load = {m[a], m[a+1]}, extended to 32 bits.
  - Byte load = m[a], extended to 32 bits.
  - Extension: sign-extend from bit 7 or 15 when req_unsigned=0; zero-extend when 1.
- Stores:
  - SB writes wdata[7:0] to m[a].
  - SH writes wdata[15:8] to m[a] and wdata[7:0] to m[a+1].
  - SW writes the big-endian word to m[a..a+3].
  - Commit occurs on the clock edge entering RESP. The memory array is updated only on that edge.
  - Store responses: resp_rdata=0, resp_error=0.
- Load data is sampled from the array in RESP, so a load issued immediately after a store to the same address returns the new data.
- Address wrap-around cannot occur: misaligned and out-of-range accesses are rejected before indexing.
- Reset mid-operation: an in-flight access is dropped with no response. A store not yet committed is discarded; memory is otherwise untouched.
- Storage: single byte array, one write port (up to 4 bytes wide), one read port.

Test Plan:
- Reset then word store/load, LATENCY=1: SW 0xDEADBEEF @0x100, then LW @0x100 → resp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, error=0; LB @0x100 → 0xFFFFFFDE, LBU @0x103 → 0x000000EF.
- Halfword and extension: SH 0x00008001 @0x202, then LH @0x202 → 0xFFFF8001, LHU @0x202 → 0x00008001, LW @0x200 → {old m[0x200..0x201], 0x80, 0x01}.
- Byte merge: SW 0x11223344 @0x40, SB 0x000000AA @0x41, then LW @0x40 → 0x11AA3344.
- Errors: LW @0x102, LH @0x101, size=11 @0x0, SW @0x4000 (ADDR_WIDTH=14) → each gives resp_error=1, rdata=0; a later LW @0x4 shows the SW left memory unchanged.
- Latency sweep with LATENCY=0 and LATENCY=3: back-to-back requests held on req_valid → req_ready high only in IDLE; resp_valid at acceptance+1 and +4 respectively; exactly one response per accepted request.
- Reset mid-operation: accept SW 0xCAFEF00D @0x10 with LATENCY=3, assert rst_n low in WAIT → no resp_valid, outputs at reset values; a subsequent LW @0x10 returns the prior contents.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressable, big-endian data memory for the MEM stage. A request is
//   accepted in IDLE. It waits LATENCY cycles and then produces a one-cycle
//   response. Byte, halfword and word accesses are supported. Loads are sign-
//   or zero-extended. Misaligned, out-of-range and invalid-size accesses are
//   rejected with resp_error and never touch the array.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 halfword, 10 word, 11 invalid
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr/req_wdata  byte address / right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result (0 for stores and errors)
//   resp_error          access rejected (qualifies resp_valid)
//   busy                request in flight
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Rejects invalid sizes, misalignment and any address bit above the array.
  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr[0];
      SZ_WORD: err = (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    return err | ((addr >> ADDR_WIDTH) != 32'd0);
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        accept_s;
  logic        write_r, uns_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;

  logic        cur_write_s;
  logic [1:0]  cur_size_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic        err_s, commit_s;

  logic [ADDR_WIDTH-1:0] idx0_s, idx1_s, idx2_s, idx3_s;
  logic [31:0] load_word_s, load_data_s;

  logic [7:0] mem_r [DEPTH];

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (LATENCY > 0) begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latch, loaded on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      write_r <= req_write;
      uns_r   <= req_unsigned;
      size_r  <= req_size;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

  // Active request: the live inputs while IDLE (needed when LATENCY=0 commits
  // on the acceptance edge), the latched copy otherwise
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_write_s = req_write;
      cur_size_s  = req_size;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
    end else begin
      cur_write_s = write_r;
      cur_size_s  = size_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign err_s  = access_error(cur_size_s, cur_addr_s);
  assign idx0_s = cur_addr_s[ADDR_WIDTH-1:0];
  assign idx1_s = idx0_s + ADDR_WIDTH'(1);
  assign idx2_s = idx0_s + ADDR_WIDTH'(2);
  assign idx3_s = idx0_s + ADDR_WIDTH'(3);

  // A store commits only on the edge entering RESP. Gating with rst_n keeps
  // a held-in-reset controller from writing.
  assign commit_s = rst_n && cur_write_s && !err_s &&
                    (state_s == ST_RESP) && (state_r != ST_RESP);

  // Byte-lane store into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      case (cur_size_s)
        SZ_BYTE: mem_r[idx0_s] <= cur_wdata_s[7:0];
        SZ_HALF: begin
          mem_r[idx0_s] <= cur_wdata_s[15:8];
          mem_r[idx1_s] <= cur_wdata_s[7:0];
        end
        SZ_WORD: begin
          mem_r[idx0_s] <= cur_wdata_s[31:24];
          mem_r[idx1_s] <= cur_wdata_s[23:16];
          mem_r[idx2_s] <= cur_wdata_s[15:8];
          mem_r[idx3_s] <= cur_wdata_s[7:0];
        end
        default: ;
      endcase
    end
  end

  // Big-endian read and extension; the lowest address lands in the top byte
  always_comb begin
    load_word_s = {mem_r[idx0_s], mem_r[idx1_s], mem_r[idx2_s], mem_r[idx3_s]};
    load_data_s = 32'd0;
    case (size_r)
      SZ_BYTE: begin
        if (uns_r) load_data_s = {24'd0, load_word_s[31:24]};
        else       load_data_s = {{24{load_word_s[31]}}, load_word_s[31:24]};
      end
      SZ_HALF: begin
        if (uns_r) load_data_s = {16'd0, load_word_s[31:16]};
        else       load_data_s = {{16{load_word_s[31]}}, load_word_s[31:16]};
      end
      SZ_WORD: load_data_s = load_word_s;
      default: load_data_s = 32'd0;
    endcase
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign resp_valid = (state_r == ST_RESP);
  assign resp_error = resp_valid && err_s;
  assign resp_rdata = (resp_valid && !write_r && !err_s) ? load_data_s : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl. Three instances share the request
// fields and reset. Instance 0 has LATENCY=1, 1 has LATENCY=0 and 2 has
// LATENCY=3. Each instance has its own req_valid.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        rdy [3];
  logic        rv  [3];
  logic        re  [3];
  logic        bz  [3];
  logic [31:0] rd  [3];

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } op_t;

  op_t sb_q [$];

  data_memory_ctrl #(.ADDR_WIDTH(14), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[0]),
    .resp_rdata(rd[0]), .resp_error(re[0]), .busy(bz[0]));

  data_memory_ctrl #(.ADDR_WIDTH(14), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[1]),
    .resp_rdata(rd[1]), .resp_error(re[1]), .busy(bz[1]));

  data_memory_ctrl #(.ADDR_WIDTH(14), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[2]),
    .resp_rdata(rd[2]), .resp_error(re[2]), .busy(bz[2]));

  function automatic op_t mk(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp, input logic err);
    return '{w: w, sz: sz, u: u, a: a, wd: wd, exp: exp, err: err};
  endfunction

  // Drives one request on instance i and reports the response and its latency
  // (negedges after the accepting edge); g_lat = -1 if nothing came back.
  task automatic issue(input int i, input op_t op, output logic [31:0] g_rd,
                       output logic g_err, output int g_lat);
    g_rd = 32'd0; g_err = 1'b0; g_lat = -1;
    @(negedge clk);
    req_write = op.w; req_size = op.sz; req_unsigned = op.u;
    req_addr = op.a; req_wdata = op.wd; req_valid[i] = 1'b1;
    for (int k = 0; k < 50 && !rdy[i]; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rv[i]) begin
        g_rd = rd[i]; g_err = re[i]; g_lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || rv[i] !== 1'b0 || rd[i] !== 32'd0 || re[i] !== 1'b0 || bz[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset inst%0d: ready=%b valid=%b rdata=%h err=%b busy=%b, expected 1 0 00000000 0 0",
                 i, rdy[i], rv[i], rd[i], re[i], bz[i]);
      end
    end
  endtask

  task automatic test_word();
    op_t ops [$]; op_t e; logic [31:0] g_rd; logic g_err; int g_lat;
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0));
    ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFFFFDE, 1'b0));
    ops.push_back(mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000EF, 1'b0));
    ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000BEEF, 1'b0));
    foreach (ops[j]) begin
      sb_q.push_back(ops[j]);
      issue(0, ops[j], g_rd, g_err, g_lat);
      e = sb_q.pop_front();
      vectors++;
      if (g_rd !== e.exp || g_err !== e.err || g_lat != 2) begin
        miscompares++;
        $display("FAIL word op%0d: rdata=%h err=%b lat=%0d, expected %h %b 2", j, g_rd, g_err, g_lat, e.exp, e.err);
      end
    end
  endtask

  task automatic test_halfword();
    op_t ops [$]; op_t e; logic [31:0] g_rd; logic g_err; int g_lat;
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h200, 32'h55667788, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'hFFFF8001, 1'b0));
    ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h00008001, 1'b0));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h55668001, 1'b0));
    ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h00000001, 1'b0));
    foreach (ops[j]) begin
      sb_q.push_back(ops[j]);
      issue(0, ops[j], g_rd, g_err, g_lat);
      e = sb_q.pop_front();
      vectors++;
      if (g_rd !== e.exp || g_err !== e.err || g_lat != 2) begin
        miscompares++;
        $display("FAIL half op%0d: rdata=%h err=%b lat=%0d, expected %h %b 2", j, g_rd, g_err, g_lat, e.exp, e.err);
      end
    end
  endtask

  task automatic test_byte_merge();
    op_t ops [$]; op_t e; logic [31:0] g_rd; logic g_err; int g_lat;
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11AA3344, 1'b0));
    ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h000011AA, 1'b0));
    ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h3FFF, 32'hFFFFFF5A, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'b00, 1'b1, 32'h3FFF, 32'h0, 32'h0000005A, 1'b0));
    foreach (ops[j]) begin
      sb_q.push_back(ops[j]);
      issue(0, ops[j], g_rd, g_err, g_lat);
      e = sb_q.pop_front();
      vectors++;
      if (g_rd !== e.exp || g_err !== e.err || g_lat != 2) begin
        miscompares++;
        $display("FAIL merge op%0d: rdata=%h err=%b lat=%0d, expected %h %b 2", j, g_rd, g_err, g_lat, e.exp, e.err);
      end
    end
  endtask

  task automatic test_errors();
    op_t ops [$]; op_t e; logic [31:0] g_rd; logic g_err; int g_lat;
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0, 32'h01234567, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h4, 32'h89ABCDEF, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h4000, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h4004, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h01234567, 1'b0));
    ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h89ABCDEF, 1'b0));
    foreach (ops[j]) begin
      sb_q.push_back(ops[j]);
      issue(0, ops[j], g_rd, g_err, g_lat);
      e = sb_q.pop_front();
      vectors++;
      if (g_rd !== e.exp || g_err !== e.err || g_lat != 2) begin
        miscompares++;
        $display("FAIL error op%0d: rdata=%h err=%b lat=%0d, expected %h %b 2", j, g_rd, g_err, g_lat, e.exp, e.err);
      end
    end
  endtask

  // req_valid held high; every accepted request must answer lat+1 negedges later
  task automatic test_latency_sweep(input int i, input int lat);
    int due [$]; int acc; int resp; int exp_acc;
    logic [31:0] g_rd; logic g_err; int g_lat;
    acc = 0; resp = 0;
    issue(i, mk(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A55A5A, 32'h0, 1'b0), g_rd, g_err, g_lat);
    vectors++;
    if (g_err !== 1'b0 || g_lat != lat + 1) begin
      miscompares++;
      $display("FAIL sweep%0d prime: err=%b lat=%0d, expected 0 %0d", lat, g_err, g_lat, lat + 1);
    end
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0;
    req_valid[i] = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 30) req_valid[i] = 1'b0;
      vectors++;
      if (rdy[i] !== ~bz[i] || (rv[i] === 1'b1 && rdy[i] !== 1'b0)) begin
        miscompares++;
        $display("FAIL sweep%0d ready cyc%0d: ready=%b busy=%b valid=%b, expected ready only when idle", lat, cyc, rdy[i], bz[i], rv[i]);
      end
      if (rv[i] === 1'b1) begin
        resp++;
        vectors++;
        if (due.size() == 0 || due[0] != cyc || rd[i] !== 32'hA5A55A5A || re[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL sweep%0d resp cyc%0d: rdata=%h err=%b due=%0d, expected A5A55A5A 0 on due cycle",
                   lat, cyc, rd[i], re[i], (due.size() == 0) ? -1 : due[0]);
        end
        if (due.size() != 0) void'(due.pop_front());
      end
      if (req_valid[i] === 1'b1 && rdy[i] === 1'b1) begin
        acc++;
        due.push_back(cyc + lat + 1);
      end
      @(negedge clk);
    end
    exp_acc = (30 + lat + 1) / (lat + 2);
    vectors++;
    if (acc != exp_acc || resp != acc || due.size() != 0) begin
      miscompares++;
      $display("FAIL sweep%0d count: accepted=%0d responses=%0d pending=%0d, expected %0d %0d 0",
               lat, acc, resp, due.size(), exp_acc, exp_acc);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] g_rd; logic g_err; int g_lat; int seen;
    issue(2, mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, 32'h0, 1'b0), g_rd, g_err, g_lat);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    vectors++;
    if (bz[2] !== 1'b1 || rv[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst wait: busy=%b valid=%b, expected 1 0", bz[2], rv[2]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rdy[2] !== 1'b1 || rv[2] !== 1'b0 || rd[2] !== 32'd0 || re[2] !== 1'b0 || bz[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst outputs: ready=%b valid=%b rdata=%h err=%b busy=%b, expected 1 0 00000000 0 0",
               rdy[2], rv[2], rd[2], re[2], bz[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv[2] === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midrst noresp: responses=%0d, expected 0", seen);
    end
    sb_q.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h01020304, 1'b0));
    issue(2, sb_q[0], g_rd, g_err, g_lat);
    vectors++;
    if (g_rd !== sb_q[0].exp || g_err !== 1'b0 || g_lat != 4) begin
      miscompares++;
      $display("FAIL midrst reload: rdata=%h err=%b lat=%0d, expected %h 0 4", g_rd, g_err, g_lat, sb_q[0].exp);
    end
    void'(sb_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 3'b000; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_word();
    test_halfword();
    test_byte_merge();
    test_errors();
    test_latency_sweep(1, 0);
    test_latency_sweep(2, 3);
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
